imdct_overlap_add: RTL and testbench
====================================

# imdct_overlap_add

Overlap-add stage of the IMDCT path; it consumes the windowed sample pairs produced by the windowing stage. For each subband it adds the first half of the current 36-sample block to the stored second half of the previous granule, stores the new second half, and emits 18 time samples per subband. When a subband's 18 pairs are consumed it pulses `overlap_done` back to the windowing stage.

## Interface
Parameters:
- `WIDTH`, 18: sample width, signed two's complement.
- `SUBBANDS`, 32: subbands per channel.
- `CHANNELS`, 2: channels with independent overlap memory.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `clear`  in  1: one-cycle pulse; zero all overlap memory (stream start or seek).
- `channel`  in  1: channel of the incoming pair.
- `subband`  in  5: subband of the incoming pair (0..31).
- `in_valid`  in  1: pair on lanes 0/1 is valid this cycle.
- `in_ready`  out  1: pair is accepted when `in_valid & in_ready`.
- `windowed_value_0`  in  WIDTH: sample at index k.
- `index_0`  in  6: k, legal range 0..17.
- `windowed_value_1`  in  WIDTH: sample at index k+18.
- `index_1`  in  6: must equal `index_0`+18.
- `out_valid`  out  1: output sample valid.
- `out_sample`  out  WIDTH: overlapped time sample.
- `out_index`  out  5: time index 0..17.
- `out_subband`  out  5: subband of the output sample.
- `out_channel`  out  1: channel of the output sample.
- `overlap_done`  out  1: one-cycle pulse after the 18th output sample of a subband.
- `err`  out  1: sticky; illegal index pair seen. Cleared only by reset or `clear`.

## Operation
- States: CLEAR, RUN. Reset enters CLEAR. A `clear` pulse enters CLEAR from any state.
- CLEAR: writes zero to all CHANNELS*SUBBANDS*18 = 1152 words, one per cycle, with an address counter from 0 to 1151. `in_ready`=0 throughout. After word 1151 is written the block enters RUN.
- RUN: `in_ready`=1.
- Memory address = {channel, subband, k}, with k = `index_0`.
- For each accepted pair:
  - Read prev[addr].
  - `out_sample` = `windowed_value_0` + prev[addr].
  - Write `windowed_value_1` into prev[addr] in the same pipeline step as the add.
- Illegal pair (`index_0` > 17, or `index_1` != `index_0`+18):
  - Dropped: no output, no memory write, not counted.
  - `err` is set.
- Addition is full-precision WIDTH+1 bits, then saturated to [-131072, 131071].
- Pair counter (0..17) counts accepted legal pairs. On the 18th, counter returns to 0 and `overlap_done` pulses with that pair's output.
- Read-after-write hazard: the same address accepted on consecutive cycles takes the pending write data by forwarding, not from memory.
- `clear` during RUN aborts the current subband:
  - The pair counter resets.
  - Pairs in flight are discarded, with no `out_valid` and no `overlap_done`.
  - `err` resets.

## Timing
- Reset values:
  - `in_ready`=0, `out_valid`=0, `out_sample`=0.
  - `out_index`, `out_subband`, `out_channel`=0.
  - `overlap_done`=0, `err`=0.
  - State=CLEAR, counters=0.
- Latency: a pair accepted at edge T produces `out_valid` at edge T+2.
  - Stage 1: memory read and capture of the inputs.
  - Stage 2: add/saturate, memory write, output registers.
- `overlap_done` is asserted in the same cycle as the `out_valid` of the 18th pair.
- Throughput: one pair per cycle sustained in RUN. There is no output backpressure.
- After reset or `clear`, the first `in_ready`=1 occurs 1152 cycles later.
- `clear` and `in_valid` in the same cycle: `clear` wins and the pair is not accepted.

## Configuration
- `IMDCT_FREQINV_EN` defined:
  - For an odd subband and odd `out_index`, the saturated sum is negated before output. This is frequency inversion.
  - Negating -131072 gives 131071.
- `IMDCT_FREQINV_EN` undefined: samples are output unmodified.

## Structure
- Shared package `imdct_pkg` holds:
  - `IMDCT_HALF` = 18 and `IMDCT_LEN` = 36.
  - Sample and index widths.
  - Saturation limits.
  - State encoding (CLEAR, RUN).
- One sub-module, `overlap_ram`: simple dual-port memory with 1152 x WIDTH words, synchronous read with 1-cycle latency, and one write port. The forwarding mux stays in the parent.

## Test plan
- Reset release: `in_ready` stays 0 for 1152 cycles, then goes 1. Every output is at its reset value during this time.
- First granule, ch0 sb3, pairs k=0..17 with lane0=100+k, lane1=-50:
  - Outputs are 100+k at T+2 for each pair.
  - `overlap_done` pulses with k=17.
- Second granule, same ch/sb, lane0=10: outputs are 10+(-50) = -40 for all k. With `IMDCT_FREQINV_EN`, odd k outputs +40.
- Saturation: stored 131000 plus lane0 100 gives 131071. Stored -131000 plus -100 gives -131072.
- Illegal pair `index_0`=5, `index_1`=22: no `out_valid`, `err`=1, memory for k=5 unchanged, counter unchanged.
- `clear` after 7 pairs of sb0:
  - No `overlap_done` fires; `in_ready` drops for 1152 cycles.
  - The next granule outputs lane0 unchanged, because the stored halves read as zero.
  - Same-address back-to-back pairs (k=4 twice) produce forwarded results.

Source files
------------

// File: rtl/imdct_pkg.sv
// Shared constants for the IMDCT overlap-add stage: block geometry, field widths,
// saturation limits and the controller state encoding.
package imdct_pkg;

  localparam int IMDCT_HALF  = 18;
  localparam int IMDCT_LEN   = 36;
  localparam int SAMPLE_W    = 18;
  localparam int INDEX_W     = 6;
  localparam int OUT_INDEX_W = 5;
  localparam int SUBBAND_W   = 5;

  function automatic int sat_hi(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  localparam int SAT_MAX = sat_hi(SAMPLE_W);
  localparam int SAT_MIN = -SAT_MAX - 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/imdct_overlap_ram.sv
// Overlap memory: simple dual-port RAM, one write port and one read port whose data
// appears one cycle after the address. A same-cycle read of the written word returns old data.
module overlap_ram
  import imdct_pkg::*;
#(
  parameter int WIDTH  = SAMPLE_W,
  parameter int DEPTH  = 1152,
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imdct_overlap_add.sv
// IMDCT overlap-add: adds each pair's first-half sample to the stored second half of the
// previous granule. Define IMDCT_FREQINV_EN to negate odd samples of odd subbands.
module imdct_overlap_add
  import imdct_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_W,
  parameter int SUBBANDS = 32,
  parameter int CHANNELS = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_channel,
  input  logic [SUBBAND_W-1:0]   i_subband,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [WIDTH-1:0]       i_windowed_value_0,
  input  logic [INDEX_W-1:0]     i_index_0,
  input  logic [WIDTH-1:0]       i_windowed_value_1,
  input  logic [INDEX_W-1:0]     i_index_1,
  output logic                   o_out_valid,
  output logic [WIDTH-1:0]       o_out_sample,
  output logic [OUT_INDEX_W-1:0] o_out_index,
  output logic [SUBBAND_W-1:0]   o_out_subband,
  output logic                   o_out_channel,
  output logic                   o_overlap_done,
  output logic                   o_err
);

  localparam int DEPTH  = CHANNELS * SUBBANDS * IMDCT_HALF;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0]      LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]      CH_STRIDE = ADDR_W'(SUBBANDS * IMDCT_HALF);
  localparam logic [ADDR_W-1:0]      SB_STRIDE = ADDR_W'(IMDCT_HALF);
  localparam logic [OUT_INDEX_W-1:0] LAST_PAIR = OUT_INDEX_W'(IMDCT_HALF - 1);
  localparam logic [INDEX_W-1:0]     MAX_K     = INDEX_W'(IMDCT_HALF - 1);

  localparam logic signed [WIDTH:0] SUM_MAX = (WIDTH + 1)'(sat_hi(WIDTH));
  localparam logic signed [WIDTH:0] SUM_MIN = ~SUM_MAX;
  localparam logic [WIDTH-1:0]      SAT_HI  = SUM_MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0]      SAT_LO  = SUM_MIN[WIDTH-1:0];

  state_e                  r_state;
  logic [ADDR_W-1:0]       r_clr_addr;
  logic                    r_in_ready;

  logic                    r_s1_valid;
  logic                    r_s1_last;
  logic                    r_s1_fwd;
  logic [WIDTH-1:0]        r_s1_fwd_data;
  logic [ADDR_W-1:0]       r_s1_addr;
  logic [WIDTH-1:0]        r_s1_v0;
  logic [WIDTH-1:0]        r_s1_v1;
  logic [OUT_INDEX_W-1:0]  r_s1_k;
  logic [SUBBAND_W-1:0]    r_s1_sb;
  logic                    r_s1_ch;
  logic [OUT_INDEX_W-1:0]  r_pair_cnt;
  logic                    r_err;

  logic                    r_out_valid;
  logic [WIDTH-1:0]        r_out_sample;
  logic [OUT_INDEX_W-1:0]  r_out_index;
  logic [SUBBAND_W-1:0]    r_out_subband;
  logic                    r_out_channel;
  logic                    r_overlap_done;

  logic                    w_accept;
  logic                    w_legal;
  logic                    w_take;
  logic [ADDR_W-1:0]       w_addr;
  logic [WIDTH-1:0]        w_rd_data;
  logic [WIDTH-1:0]        w_prev;
  logic signed [WIDTH:0]   w_sum;
  logic [WIDTH-1:0]        w_sat;
  logic [WIDTH-1:0]        w_result;
  logic                    w_emit;
  logic                    w_wr_en;
  logic [ADDR_W-1:0]       w_wr_addr;
  logic [WIDTH-1:0]        w_wr_data;

  assign w_accept = i_in_valid & r_in_ready & ~i_clear;
  assign w_legal  = (i_index_0 <= MAX_K) &&
                    ({1'b0, i_index_1} == ({1'b0, i_index_0} + (INDEX_W + 1)'(IMDCT_HALF)));
  assign w_take   = w_accept & w_legal;
  assign w_addr   = ADDR_W'(i_channel) * CH_STRIDE + ADDR_W'(i_subband) * SB_STRIDE
                  + ADDR_W'(i_index_0);

  // Controller: sweep zeros through the whole memory, then accept pairs until the next clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_in_ready <= 1'b0;
    end else if (i_clear) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_in_ready <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_addr == LAST_ADDR) begin
        r_state    <= ST_RUN;
        r_clr_addr <= '0;
        r_in_ready <= 1'b1;
      end else begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
    end else begin
      r_in_ready <= 1'b1;
    end
  end

  // The word being written this cycle is still stale in the RAM read, so hand it over directly.
  assign w_prev = r_s1_fwd ? r_s1_fwd_data : w_rd_data;
  assign w_sum  = $signed({r_s1_v0[WIDTH-1], r_s1_v0}) + $signed({w_prev[WIDTH-1], w_prev});

  always_comb begin
    if (w_sum > SUM_MAX) begin
      w_sat = SAT_HI;
    end else if (w_sum < SUM_MIN) begin
      w_sat = SAT_LO;
    end else begin
      w_sat = w_sum[WIDTH-1:0];
    end
  end

`ifdef IMDCT_FREQINV_EN
  always_comb begin
    w_result = w_sat;
    if (r_s1_sb[0] && r_s1_k[0]) begin
      w_result = (w_sat == SAT_LO) ? SAT_HI : -w_sat;
    end
  end
`else
  assign w_result = w_sat;
`endif

  assign w_emit    = r_s1_valid & ~i_clear;
  assign w_wr_en   = (r_state == ST_CLEAR) | w_emit;
  assign w_wr_addr = (r_state == ST_CLEAR) ? r_clr_addr : r_s1_addr;
  assign w_wr_data = (r_state == ST_CLEAR) ? '0 : r_s1_v1;

  overlap_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rd_addr (w_addr),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data)
  );

  // Stage 1 captures the accepted pair alongside the RAM read; a clear drops everything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_last     <= 1'b0;
      r_s1_fwd      <= 1'b0;
      r_s1_fwd_data <= '0;
      r_s1_addr     <= '0;
      r_s1_v0       <= '0;
      r_s1_v1       <= '0;
      r_s1_k        <= '0;
      r_s1_sb       <= '0;
      r_s1_ch       <= 1'b0;
      r_pair_cnt    <= '0;
      r_err         <= 1'b0;
    end else begin
      r_s1_valid <= w_take;
      r_s1_last  <= w_take && (r_pair_cnt == LAST_PAIR);
      if (w_take) begin
        r_s1_fwd      <= r_s1_valid && (r_s1_addr == w_addr);
        r_s1_fwd_data <= r_s1_v1;
        r_s1_addr     <= w_addr;
        r_s1_v0       <= i_windowed_value_0;
        r_s1_v1       <= i_windowed_value_1;
        r_s1_k        <= i_index_0[OUT_INDEX_W-1:0];
        r_s1_sb       <= i_subband;
        r_s1_ch       <= i_channel;
      end
      if (i_clear) begin
        r_pair_cnt <= '0;
        r_err      <= 1'b0;
      end else begin
        if (w_take) begin
          r_pair_cnt <= (r_pair_cnt == LAST_PAIR) ? '0 : r_pair_cnt + 1'b1;
        end
        if (w_accept && !w_legal) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Stage 2 registers the overlapped sample while the new second half is written back.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid    <= 1'b0;
      r_out_sample   <= '0;
      r_out_index    <= '0;
      r_out_subband  <= '0;
      r_out_channel  <= 1'b0;
      r_overlap_done <= 1'b0;
    end else begin
      r_out_valid    <= w_emit;
      r_overlap_done <= w_emit & r_s1_last;
      if (w_emit) begin
        r_out_sample  <= w_result;
        r_out_index   <= r_s1_k;
        r_out_subband <= r_s1_sb;
        r_out_channel <= r_s1_ch;
      end
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_out_valid    = r_out_valid;
  assign o_out_sample   = r_out_sample;
  assign o_out_index    = r_out_index;
  assign o_out_subband  = r_out_subband;
  assign o_out_channel  = r_out_channel;
  assign o_overlap_done = r_overlap_done;
  assign o_err          = r_err;

endmodule

// File: tb/tb_imdct_overlap_add.sv
// Testbench for imdct_overlap_add: directed granules plus random traffic, checked every
// cycle against an array-based overlap-add model (honours IMDCT_FREQINV_EN).
module tb_imdct_overlap_add;

   logic        clk;
   logic        rstN;
   logic        clear;
   logic        channel;
   logic [4:0]  subband;
   logic        inValid;
   logic        inReady;
   logic [17:0] value0;
   logic [5:0]  index0;
   logic [17:0] value1;
   logic [5:0]  index1;
   logic        outValid;
   logic [17:0] outSample;
   logic [4:0]  outIndex;
   logic [4:0]  outSubband;
   logic        outChannel;
   logic        overlapDone;
   logic        err;

   typedef struct {
      int due;
      int sample;
      int idx;
      int sb;
      int ch;
      int done;
   } exp_t;

   exp_t expQ[$];
   int   memModel[2][32][18];
   int   cyc;
   int   total;
   int   bad;
   int   pairCount;
   int   readyFrom;
   int   errModel;
   bit   seenOutput;

   imdct_overlap_add dut (
      .i_clk              (clk),
      .i_rst_n            (rstN),
      .i_clear            (clear),
      .i_channel          (channel),
      .i_subband          (subband),
      .i_in_valid         (inValid),
      .o_in_ready         (inReady),
      .i_windowed_value_0 (value0),
      .i_index_0          (index0),
      .i_windowed_value_1 (value1),
      .i_index_1          (index1),
      .o_out_valid        (outValid),
      .o_out_sample       (outSample),
      .o_out_index        (outIndex),
      .o_out_subband      (outSubband),
      .o_out_channel      (outChannel),
      .o_overlap_done     (overlapDone),
      .o_err              (err)
   );

   // Free-running clock; every observation happens on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic int satModel(input int s);
      if (s > 131071) return 131071;
      if (s < -131072) return -131072;
      return s;
   endfunction

   // Compares all outputs against what the model says this cycle should show.
   task automatic checkCycle();
      exp_t e;
      checkOutput("in_ready", inReady, (cyc >= readyFrom) ? 1 : 0);
      checkOutput("err", err, errModel);
      if (expQ.size() > 0 && expQ[0].due == cyc) begin
         e = expQ.pop_front();
         seenOutput = 1'b1;
         checkOutput("out_valid", outValid, 1);
         checkOutput("out_sample", $signed(outSample), e.sample);
         checkOutput("out_index", outIndex, e.idx);
         checkOutput("out_subband", outSubband, e.sb);
         checkOutput("out_channel", outChannel, e.ch);
         checkOutput("overlap_done", overlapDone, e.done);
      end else begin
         checkOutput("out_valid_idle", outValid, 0);
         checkOutput("overlap_done_idle", overlapDone, 0);
         if (!seenOutput) begin
            checkOutput("rst_out_sample", $signed(outSample), 0);
            checkOutput("rst_out_index", outIndex, 0);
            checkOutput("rst_out_subband", outSubband, 0);
            checkOutput("rst_out_channel", outChannel, 0);
         end
      end
   endtask

   // Drives one cycle of input, advances the model for that clock edge, then checks.
   task automatic applyStimulus(input bit valid, input int ch, input int sb, input int v0,
                                input int i0, input int v1, input int i1, input bit clr);
      exp_t e;
      int   s;
      i0 = i0 & 63;
      i1 = i1 & 63;
      ch = ch & 1;
      sb = sb & 31;
      inValid = valid;
      clear   = clr;
      channel = ch[0];
      subband = sb[4:0];
      value0  = v0[17:0];
      index0  = i0[5:0];
      value1  = v1[17:0];
      index1  = i1[5:0];
      if (clr) begin
         expQ.delete();
         foreach (memModel[a, b, c]) memModel[a][b][c] = 0;
         pairCount = 0;
         errModel  = 0;
         readyFrom = cyc + 1153;
      end else if (valid && cyc >= readyFrom) begin
         if (i0 <= 17 && i1 == i0 + 18) begin
            s = satModel(v0 + memModel[ch][sb][i0]);
`ifdef IMDCT_FREQINV_EN
            if ((sb % 2 == 1) && (i0 % 2 == 1)) s = (s == -131072) ? 131071 : -s;
`endif
            memModel[ch][sb][i0] = v1;
            pairCount++;
            e.done = (pairCount == 18) ? 1 : 0;
            if (pairCount == 18) pairCount = 0;
            e.due = cyc + 2; e.sample = s; e.idx = i0; e.sb = sb; e.ch = ch;
            expQ.push_back(e);
         end else begin
            errModel = 1;
         end
      end
      @(negedge clk);
      cyc++;
      checkCycle();
   endtask

   task automatic waitReady();
      int guard;
      guard = 0;
      while (cyc < readyFrom && guard < 2000) begin
         applyStimulus(1'b1, 0, 0, 7, 0, 9, 18, 1'b0);
         guard++;
      end
      checkOutput("ready_after_clear", inReady, 1);
   endtask

   task automatic randomTraffic(input int n);
      int ch, sb, k, i1, v0, v1;
      bit vld;
      for (int j = 0; j < n; j++) begin
         vld = ($urandom_range(0, 9) < 7);
         ch  = $urandom_range(0, 1);
         sb  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1) : $urandom_range(0, 31);
         k   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : $urandom_range(0, 17);
         i1  = k + 18;
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 1) == 1) k = $urandom_range(18, 63);
            else i1 = $urandom_range(0, 63);
         end
         v0 = int'($urandom_range(0, 262143)) - 131072;
         v1 = int'($urandom_range(0, 262143)) - 131072;
         applyStimulus(vld, ch, sb, v0, k, v1, i1, 1'b0);
      end
   endtask

   initial begin
      int seq[19];
      total = 0; bad = 0; cyc = 0; pairCount = 0; errModel = 0; seenOutput = 1'b0;
      readyFrom = 1152;
      foreach (memModel[a, b, c]) memModel[a][b][c] = 0;
      rstN = 1'b0; clear = 1'b0; inValid = 1'b0; channel = 1'b0; subband = '0;
      value0 = '0; index0 = '0; value1 = '0; index1 = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset_in_ready", inReady, 0);
      checkOutput("reset_out_valid", outValid, 0);
      checkOutput("reset_err", err, 0);
      rstN = 1'b1;
      cyc  = 0;

      $display("[TB] waiting out the initial memory clear");
      waitReady();

      $display("[TB] first and second granule on ch0 sb3");
      for (int k = 0; k < 18; k++) applyStimulus(1'b1, 0, 3, 100 + k, k, -50, k + 18, 1'b0);
      for (int k = 0; k < 18; k++) applyStimulus(1'b1, 0, 3, 10, k, 1000 + k, k + 18, 1'b0);

      $display("[TB] illegal pairs, then a third granule reading sb3 back");
      applyStimulus(1'b1, 0, 3, 999, 5, 999, 22, 1'b0);
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
      applyStimulus(1'b1, 0, 3, 999, 20, 999, 38, 1'b0);
      for (int k = 0; k < 18; k++) applyStimulus(1'b1, 0, 3, 0, k, 0, k + 18, 1'b0);

      $display("[TB] saturation on ch1 sb5");
      for (int k = 0; k < 18; k++)
         applyStimulus(1'b1, 1, 5, 0, k, (k == 0) ? 131000 : (k == 1) ? -131000 : 3, k + 18, 1'b0);
      for (int k = 0; k < 18; k++)
         applyStimulus(1'b1, 1, 5, (k == 0) ? 100 : (k == 1) ? -100 : -7, k, 0, k + 18, 1'b0);

      $display("[TB] clear in the middle of sb0");
      for (int k = 0; k < 7; k++) applyStimulus(1'b1, 0, 0, 500, k, 600, k + 18, 1'b0);
      applyStimulus(1'b1, 0, 0, 500, 7, 600, 25, 1'b1);
      waitReady();

      $display("[TB] post-clear granule with back-to-back k=4");
      for (int i = 0; i < 19; i++) seq[i] = (i <= 4) ? i : i - 1;
      for (int i = 0; i < 19; i++) applyStimulus(1'b1, 0, 0, 200 + seq[i], seq[i], 300 + i, seq[i] + 18, 1'b0);
      for (int k = 0; k < 18; k++) applyStimulus(1'b1, 0, 0, 1, k, 0, k + 18, 1'b0);

      $display("[TB] random traffic");
      randomTraffic(400);
      applyStimulus(1'b1, 1, 1, 42, 3, 43, 21, 1'b0);
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
      waitReady();
      randomTraffic(150);

      repeat (4) applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 1'b0);
      checkOutput("drain_empty", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
